// File: rtl/apb_gpio_bridge_mc.sv
// apb_gpio_bridge_mc: APB3 slave that decodes one bus onto NCH GPIO cores.
// Core accesses wait for core_ack or time out with an error response. Index
// NCH selects a local interrupt block (mask / pending / raw). Higher indices
// return a decode error.
//
// state | meaning
// IDLE  | waiting for an APB setup phase (PSEL & !PENABLE)
// BUSY  | core access in flight, core_sel held, timeout counter running
// DONE  | PREADY high for one cycle with PSLVERR/PRDATA valid
module apb_gpio_bridge_mc #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int NCH      = 4,
   parameter int WIN_BITS = 8,
   parameter int TIMEOUT  = 15
) (
   input  logic                  PCLK,
   input  logic                  sys_rst,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_W-1:0]     PADDR,
   input  logic [DATA_W-1:0]     PWDATA,
   output logic [DATA_W-1:0]     PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  IRQ,
   output logic [NCH-1:0]        core_sel,
   output logic                  core_we,
   output logic [WIN_BITS-1:0]   core_addr,
   output logic [DATA_W-1:0]     core_wdata,
   input  logic [NCH*DATA_W-1:0] core_rdata,
   input  logic [NCH-1:0]        core_ack,
   input  logic [NCH-1:0]        core_int
);

   localparam int IDX_W = $clog2(NCH + 1);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0]    LOC_IDX  = IDX_W'(NCH);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [WIN_BITS-1:0] OFF_MASK = WIN_BITS'(0);
   localparam logic [WIN_BITS-1:0] OFF_PEND = WIN_BITS'(4);
   localparam logic [WIN_BITS-1:0] OFF_RAW  = WIN_BITS'(8);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    tmo_cnt;
   logic [NCH-1:0]      int_mask;
   logic [NCH-1:0]      int_pend;
   logic [NCH-1:0]      int_prev;

   logic [IDX_W-1:0]    idx;
   logic [WIN_BITS-1:0] offset;
   logic                setup;
   logic                is_core;
   logic                is_local;
   logic                mask_wr;
   logic                pend_wr;
   logic [NCH-1:0]      sel_dec;
   logic [DATA_W-1:0]   loc_rdata;
   logic [DATA_W-1:0]   ack_rdata;
   logic                unused_paddr_hi;

   assign idx      = PADDR[WIN_BITS +: IDX_W];
   assign offset   = PADDR[WIN_BITS-1:0];
   assign is_core  = (idx < LOC_IDX);
   assign is_local = (idx == LOC_IDX);
   assign setup    = (state == IDLE) && PSEL && !PENABLE;
   assign mask_wr  = setup && is_local && PWRITE && (offset == OFF_MASK);
   assign pend_wr  = setup && is_local && PWRITE && (offset == OFF_PEND);

   // address bits above the channel index are don't-care
   assign unused_paddr_hi = ^PADDR[ADDR_W-1:WIN_BITS+IDX_W];

   // one-hot strobe for the decoded channel
   always_comb begin
      sel_dec = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_dec[i] = (idx == IDX_W'(i));
      end
   end

   // read data of the channel currently selected
   always_comb begin
      ack_rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (core_sel[i]) begin
            ack_rdata = ack_rdata | core_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // local register read mux; unmapped offsets read zero
   always_comb begin
      loc_rdata = '0;
      case (offset)
         OFF_MASK: loc_rdata[NCH-1:0] = int_mask;
         OFF_PEND: loc_rdata[NCH-1:0] = int_pend;
         OFF_RAW:  loc_rdata[NCH-1:0] = core_int;
         default:  loc_rdata = '0;
      endcase
   end

   // interrupt edge capture, mask/pending registers and registered IRQ;
   // a new rising edge wins over a same-cycle W1C
   always_ff @(posedge PCLK or posedge sys_rst) begin
      if (sys_rst) begin
         int_mask <= '0;
         int_pend <= '0;
         int_prev <= '0;
         IRQ      <= 1'b0;
      end else begin
         int_prev <= core_int;
         int_pend <= (int_pend & ~(pend_wr ? PWDATA[NCH-1:0] : '0)) | (core_int & ~int_prev);
         if (mask_wr) begin
            int_mask <= PWDATA[NCH-1:0];
         end
         IRQ <= |(int_pend & int_mask);
      end
   end

   // transfer FSM with registered APB response and core strobes
   always_ff @(posedge PCLK or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         tmo_cnt    <= '0;
         PREADY     <= 1'b0;
         PSLVERR    <= 1'b0;
         PRDATA     <= '0;
         core_sel   <= '0;
         core_we    <= 1'b0;
         core_addr  <= '0;
         core_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
               PRDATA  <= '0;
               if (setup) begin
                  core_we    <= PWRITE;
                  core_addr  <= offset;
                  core_wdata <= PWDATA;
                  if (is_core) begin
                     state    <= BUSY;
                     core_sel <= sel_dec;
                     tmo_cnt  <= '0;
                  end else begin
                     state   <= DONE;
                     PREADY  <= 1'b1;
                     PSLVERR <= !is_local;
                     PRDATA  <= (is_local && !PWRITE) ? loc_rdata : '0;
                  end
               end
            end
            BUSY: begin
               if (|(core_ack & core_sel)) begin
                  state    <= DONE;
                  PREADY   <= 1'b1;
                  PSLVERR  <= 1'b0;
                  PRDATA   <= core_we ? '0 : ack_rdata;
                  core_sel <= '0;
               end else if (tmo_cnt == CNT_LAST) begin
                  state    <= DONE;
                  PREADY   <= 1'b1;
                  PSLVERR  <= 1'b1;
                  PRDATA   <= '0;
                  core_sel <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state   <= IDLE;
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
               PRDATA  <= '0;
            end
            default: begin
               state    <= IDLE;
               core_sel <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_gpio_bridge_mc.sv
// Bench for apb_gpio_bridge_mc: transaction driver that predicts each cycle
// of a transfer, an interrupt reference model, and a per-cycle compare.
module tb_apb_gpio_bridge_mc;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int NCH      = 4;
   localparam int WIN_BITS = 8;
   localparam int TIMEOUT  = 15;
   localparam int IDX_W    = $clog2(NCH + 1);
   localparam logic [31:0] LOC = 32'h0000_0400;

   logic                  PCLK = 1'b0;
   logic                  sys_rst = 1'b1;
   logic                  PSEL = 1'b0;
   logic                  PENABLE = 1'b0;
   logic                  PWRITE = 1'b0;
   logic [ADDR_W-1:0]     PADDR = '0;
   logic [DATA_W-1:0]     PWDATA = '0;
   logic [DATA_W-1:0]     PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   logic                  IRQ;
   logic [NCH-1:0]        core_sel;
   logic                  core_we;
   logic [WIN_BITS-1:0]   core_addr;
   logic [DATA_W-1:0]     core_wdata;
   logic [NCH*DATA_W-1:0] core_rdata = '0;
   logic [NCH-1:0]        core_ack = '0;
   logic [NCH-1:0]        core_int = '0;

   apb_gpio_bridge_mc #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .WIN_BITS(WIN_BITS), .TIMEOUT(TIMEOUT)
   ) dut (
      .PCLK(PCLK), .sys_rst(sys_rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .IRQ(IRQ), .core_sel(core_sel), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack), .core_int(core_int)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_bad = 0;

   // expected per-cycle APB/core view, written by the driver
   bit                  chk_en = 0;
   bit                  int_en = 0;
   logic                exp_pready = 0;
   logic                exp_err = 0;
   logic [DATA_W-1:0]   exp_rdata = '0;
   logic [NCH-1:0]      exp_sel = '0;
   logic                exp_we = 0;
   logic [WIN_BITS-1:0] exp_addr = '0;
   logic [DATA_W-1:0]   exp_wdata = '0;

   // local-register request handed to the interrupt model for the setup edge
   bit                  loc_req = 0;
   bit                  loc_wr = 0;
   logic [WIN_BITS-1:0] loc_off = '0;
   logic [DATA_W-1:0]   loc_wdata = '0;

   // interrupt reference model
   logic [NCH-1:0]      m_mask = '0;
   logic [NCH-1:0]      m_pend = '0;
   logic [NCH-1:0]      m_last_int = '0;
   logic [NCH-1:0]      m_clear = '0;
   logic                m_irq = 0;
   logic [DATA_W-1:0]   m_loc_rdata = '0;

   // observations of the DUT made by the driver within one transfer
   int                  obs_wait;
   int                  obs_rdy;
   logic [NCH-1:0]      obs_sel_first;
   logic [NCH-1:0]      obs_sel_any;
   logic [NCH-1:0]      obs_sel_done;
   logic [WIN_BITS-1:0] obs_addr;
   logic [DATA_W-1:0]   obs_wdata;
   logic [DATA_W-1:0]   last_rdata;
   logic                last_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pending bits latch on a 0->1 sample of core_int, local W1C clears
   // lose against a fresh edge, IRQ shows the masked pending of the previous cycle.
   always @(posedge PCLK or posedge sys_rst) begin
      if (sys_rst) begin
         m_mask = '0; m_pend = '0; m_last_int = '0; m_irq = 0; m_loc_rdata = '0;
      end else begin
         m_irq = |(m_pend & m_mask);
         m_clear = '0;
         if (loc_req) begin
            case (loc_off)
               8'h00:   m_loc_rdata = DATA_W'(m_mask);
               8'h04:   m_loc_rdata = DATA_W'(m_pend);
               8'h08:   m_loc_rdata = DATA_W'(core_int);
               default: m_loc_rdata = '0;
            endcase
            if (loc_wr && loc_off == 8'h00) m_mask = loc_wdata[NCH-1:0];
            if (loc_wr && loc_off == 8'h04) m_clear = loc_wdata[NCH-1:0];
         end
         for (int i = 0; i < NCH; i++) begin
            if (core_int[i] && !m_last_int[i]) m_pend[i] = 1'b1;
            else if (m_clear[i])               m_pend[i] = 1'b0;
         end
         m_last_int = core_int;
      end
   end

   // per-cycle compare of DUT against the expectations
   always @(negedge PCLK) begin
      if (chk_en && !sys_rst) begin
         check("pready", PREADY, exp_pready);
         if (exp_pready) check("pslverr", PSLVERR, exp_err);
         check("prdata", PRDATA, exp_rdata);
         check("core_sel", core_sel, exp_sel);
         check("irq", IRQ, m_irq);
         if (exp_sel != '0) begin
            check("core_we", core_we, exp_we);
            check("core_addr", core_addr, exp_addr);
            check("core_wdata", core_wdata, exp_wdata);
         end
      end
   end

   // random core_int activity
   initial begin
      forever begin
         @(posedge PCLK); #1;
         if (int_en && $urandom_range(0, 5) == 0)
            core_int[$urandom_range(0, NCH-1)] ^= 1'b1;
      end
   end

   task automatic observe();
      obs_wait += (PREADY === 1'b0) ? 1 : 0;
      obs_rdy  += (PREADY === 1'b1) ? 1 : 0;
      obs_sel_any |= core_sel;
   endtask

   // One complete transfer, called at posedge+1 with the DUT idle. ack_d is the
   // cycle (1-based after setup) in which the selected core acks; beyond
   // TIMEOUT the access times out. drop releases PSEL/PENABLE after setup.
   task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                           input int ack_d, input bit drop, input bit rd_fix,
                           input logic [31:0] rd_val);
      logic [IDX_W-1:0] idx_bits;
      int               idx;
      int               nw;
      bit               to;
      logic [31:0]      rsl;
      logic [NCH-1:0]   oh;
      idx_bits = addr[WIN_BITS +: IDX_W];
      idx = int'(idx_bits);
      PSEL = 1; PENABLE = 0; PADDR = addr; PWRITE = wr; PWDATA = wdata; core_ack = '0;
      loc_req = (idx == NCH); loc_wr = wr; loc_off = addr[WIN_BITS-1:0]; loc_wdata = wdata;
      obs_wait = 0; obs_rdy = 0; obs_sel_any = '0; obs_sel_first = '0;
      @(posedge PCLK); #1;
      loc_req = 0;
      PSEL = !drop; PENABLE = !drop;
      rsl = '0; to = 0;
      if (idx < NCH) begin
         oh = '0; oh[idx] = 1'b1;
         to = (ack_d > TIMEOUT);
         nw = to ? TIMEOUT : ack_d;
         for (int w = 1; w <= nw; w++) begin
            exp_sel = oh; exp_we = wr; exp_addr = addr[WIN_BITS-1:0]; exp_wdata = wdata;
            exp_pready = 0; exp_err = 0; exp_rdata = '0;
            if (w == 1) begin
               obs_sel_first = core_sel; obs_addr = core_addr; obs_wdata = core_wdata;
            end
            observe();
            for (int c = 0; c < NCH; c++) core_rdata[c*DATA_W +: DATA_W] = $urandom;
            if (rd_fix) core_rdata[idx*DATA_W +: DATA_W] = rd_val;
            core_ack = NCH'($urandom) & ~oh;
            if (w == ack_d) begin
               core_ack = core_ack | oh;
               rsl = core_rdata[idx*DATA_W +: DATA_W];
            end
            @(posedge PCLK); #1;
         end
         exp_sel = '0; exp_pready = 1; exp_err = to;
         exp_rdata = (wr || to) ? '0 : rsl;
      end else begin
         exp_pready = 1; exp_err = (idx > NCH);
         exp_rdata = (idx == NCH && !wr) ? m_loc_rdata : '0;
      end
      observe();
      last_rdata = PRDATA; last_err = PSLVERR; obs_sel_done = core_sel;
      core_ack = NCH'($urandom);
      @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0; core_ack = '0;
      exp_pready = 0; exp_err = 0; exp_rdata = '0;
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      int          id;
      int          d;

      // reset values
      #2;
      check("rst_pready", PREADY, 0);
      check("rst_pslverr", PSLVERR, 0);
      check("rst_irq", IRQ, 0);
      check("rst_core_sel", core_sel, 0);
      check("rst_core_we", core_we, 0);
      check("rst_prdata", PRDATA, 0);
      check("rst_core_addr", core_addr, 0);
      check("rst_core_wdata", core_wdata, 0);
      @(posedge PCLK); #1;
      sys_rst = 0;
      chk_en = 1;
      @(posedge PCLK); #1;

      // write then read channel 1
      apb_xfer(32'h0000_0110, 1, 32'd201, 2, 0, 0, 0);
      check("ch1_wr_sel", obs_sel_first, 4'b0010);
      check("ch1_wr_addr", obs_addr, 8'h10);
      check("ch1_wr_wdata", obs_wdata, 201);
      check("ch1_wr_waits", obs_wait, 2);
      check("ch1_wr_err", last_err, 0);
      apb_xfer(32'h0000_0110, 0, 0, 1, 0, 1, 32'd201);
      check("ch1_rd_data", last_rdata, 201);
      check("ch1_rd_waits", obs_wait, 1);

      // timeout on channel 3
      apb_xfer(32'h0000_0300, 0, 0, 100, 0, 0, 0);
      check("tmo_waits", obs_wait, TIMEOUT);
      check("tmo_err", last_err, 1);
      check("tmo_rdata", last_rdata, 0);
      check("tmo_sel_done", obs_sel_done, 0);

      // decode error
      apb_xfer(32'h0000_0500, 1, 32'hFFFF_FFFF, 1, 0, 0, 0);
      check("dec_waits", obs_wait, 0);
      check("dec_ready_cycles", obs_rdy, 1);
      check("dec_err", last_err, 1);
      check("dec_no_sel", obs_sel_any, 0);

      // interrupts
      apb_xfer(LOC + 32'h0, 1, 32'h5, 1, 0, 0, 0);
      core_int = 4'b0011;
      @(posedge PCLK); #1;
      check("irq_lat1", IRQ, 0);
      @(posedge PCLK); #1;
      check("irq_lat2", IRQ, 1);
      apb_xfer(LOC + 32'h4, 0, 0, 1, 0, 0, 0);
      check("pend_rd", last_rdata, 32'h3);
      check("pend_rd_err", last_err, 0);
      apb_xfer(LOC + 32'h4, 1, 32'h1, 1, 0, 0, 0);
      check("irq_after_w1c", IRQ, 0);
      apb_xfer(LOC + 32'h8, 0, 0, 1, 0, 0, 0);
      check("raw_rd", last_rdata, 32'h3);
      core_int[0] = 1'b0;
      repeat (2) begin @(posedge PCLK); #1; end
      core_int[0] = 1'b1;
      apb_xfer(LOC + 32'h4, 1, 32'h1, 1, 0, 0, 0);
      apb_xfer(LOC + 32'h4, 0, 0, 1, 0, 0, 0);
      check("pend_set_wins", last_rdata, 32'h3);
      apb_xfer(LOC + 32'h10, 0, 0, 1, 0, 0, 0);
      check("unmapped_rd", last_rdata, 0);
      check("unmapped_err", last_err, 0);

      // abandoned transfer on channel 0, then a normal one
      apb_xfer(32'h0000_0000, 1, 32'h1234, 3, 1, 0, 0);
      check("aband_waits", obs_wait, 3);
      check("aband_ready_cycles", obs_rdy, 1);
      apb_xfer(32'h0000_0020, 0, 0, 1, 0, 1, 32'hA5A5_0001);
      check("after_aband_rd", last_rdata, 32'hA5A5_0001);
      check("after_aband_waits", obs_wait, 1);

      // reset in the middle of a channel 2 access
      check("pre_rst_irq", IRQ, 1);
      chk_en = 0;
      PSEL = 1; PENABLE = 0; PADDR = 32'h0000_0200; PWRITE = 0;
      @(posedge PCLK); #1;
      PENABLE = 1;
      @(posedge PCLK); #1;
      check("busy_sel_ch2", core_sel, 4'b0100);
      #2;
      sys_rst = 1;
      #1;
      check("midrst_sel", core_sel, 0);
      check("midrst_pready", PREADY, 0);
      check("midrst_irq", IRQ, 0);
      PSEL = 0; PENABLE = 0; core_int = '0;
      @(posedge PCLK); #1;
      sys_rst = 0;
      chk_en = 1;
      apb_xfer(LOC + 32'h0, 0, 0, 1, 0, 0, 0);
      check("mask_after_rst", last_rdata, 0);

      // randomized traffic with random interrupt activity
      int_en = 1;
      for (int n = 0; n < 250; n++) begin
         k = $urandom_range(0, 9);
         if (k < 6)      id = $urandom_range(0, NCH-1);
         else if (k < 8) id = NCH;
         else            id = $urandom_range(NCH+1, 7);
         a = $urandom;
         a[WIN_BITS +: IDX_W] = IDX_W'(id);
         if (id == NCH) begin
            case ($urandom_range(0, 4))
               0:       a[WIN_BITS-1:0] = 8'h00;
               1:       a[WIN_BITS-1:0] = 8'h04;
               2:       a[WIN_BITS-1:0] = 8'h08;
               3:       a[WIN_BITS-1:0] = 8'h0C;
               default: a[WIN_BITS-1:0] = 8'h01;
            endcase
         end
         d = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 12);
         apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, d, ($urandom_range(0, 9) == 0),
                  0, 0);
         repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
      end
      int_en = 0;
      repeat (4) begin @(posedge PCLK); #1; end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
